gpio_ctrl_intr_dispatch: RTL and testbench

// Round-robin interrupt dispatcher between gpio_ctrl_intr_status_csr and the CPU.

---
 rtl/gpio_ctrl_intr_dispatch_if.sv | 26 ++
 rtl/gpio_ctrl_intr_dispatch.sv | 107 ++++++++++
 tb/tb_gpio_ctrl_intr_dispatch.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_ctrl_intr_dispatch_if.sv
// CPU claim/complete handshake plus the APB write port that clears the serviced status bit.
// The dispatcher drives the master modport; the CPU/CSR side uses the slave modport.
interface gpio_ctrl_intr_dispatch_if #(
  parameter int ID_W = 3
);
  logic            irq;
  logic [ID_W-1:0] irq_id;
  logic            claim;
  logic            complete;
  logic            m_psel;
  logic            m_penable;
  logic            m_pwrite;
  logic [3:0]      m_pstrb;
  logic [31:0]     m_pwdata;
  logic            m_pready;

  modport master (
    output irq, irq_id, m_psel, m_penable, m_pwrite, m_pstrb, m_pwdata,
    input  claim, complete, m_pready
  );

  modport slave (
    input  irq, irq_id, m_psel, m_penable, m_pwrite, m_pstrb, m_pwdata,
    output claim, complete, m_pready
  );
endinterface

// File: rtl/gpio_ctrl_intr_dispatch.sv
// Round-robin interrupt dispatcher: irq 2 cycles after pend seen in IDLE; claim/complete handshake,
// then an APB W1C clear that stalls on m_pready with no timeout, then a holdoff gap.
module gpio_ctrl_intr_dispatch #(
  parameter int NUM_BANKS      = 8,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int ID_W           = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_BANKS-1:0]    intr_status,
  input  logic [NUM_BANKS-1:0]    bank_en,
  output logic                    busy,
  gpio_ctrl_intr_dispatch_if.master bus
);
  localparam int CW = ID_W + 1;

  typedef enum logic [2:0] {
    IDLE, SELECT, PRESENT, ACTIVE, SETUP, ACCESS, HOLDOFF
  } state_t;

  state_t               state, state_nx;
  logic [NUM_BANKS-1:0] pend;
  logic                 pend_hit;
  logic [ID_W-1:0]      rr_ptr, irq_id, win;
  logic                 win_vld;
  logic [CW-1:0]        cand;
  logic [7:0]           holdoff_cnt;
  logic                 apb_nx;
  logic                 psel_q, penable_q, pwrite_q;
  logic [3:0]           pstrb_q;
  logic [31:0]          pwdata_q;

  assign pend     = intr_status & bank_en;
  assign pend_hit = |(pend & (NUM_BANKS'(1) << irq_id));

  // First pending bank at or above rr_ptr, wrapping modulo NUM_BANKS.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_BANKS)) cand = cand - CW'(NUM_BANKS);
      if (!win_vld && pend[cand[ID_W-1:0]]) begin
        win     = cand[ID_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|pend) state_nx = SELECT;
      SELECT:  state_nx = win_vld ? PRESENT : IDLE;
      PRESENT: begin
        if (bus.claim)     state_nx = ACTIVE;
        else if (!pend_hit) state_nx = IDLE;
      end
      ACTIVE:  if (bus.complete) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (bus.m_pready) state_nx = HOLDOFF;
      HOLDOFF: if (holdoff_cnt <= 8'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign apb_nx = (state_nx == SETUP) || (state_nx == ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      irq_id      <= '0;
      holdoff_cnt <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == SELECT && win_vld) irq_id <= win;
      if (state == ACCESS && bus.m_pready) begin
        rr_ptr      <= (irq_id == ID_W'(NUM_BANKS - 1)) ? '0 : irq_id + 1'b1;
        holdoff_cnt <= 8'(HOLDOFF_CYCLES);
      end else if (state == HOLDOFF && holdoff_cnt != 8'd0) begin
        holdoff_cnt <= holdoff_cnt - 8'd1;
      end
      // APB drive is registered from the next state so it aligns with SETUP/ACCESS exactly.
      psel_q    <= apb_nx;
      penable_q <= (state_nx == ACCESS);
      pwrite_q  <= apb_nx;
      pwdata_q  <= apb_nx ? (32'd1 << irq_id) : 32'd0;
      pstrb_q   <= apb_nx ? (4'd1 << (irq_id >> 3)) : 4'd0;
    end
  end

  assign busy          = (state != IDLE);
  assign bus.irq       = (state == PRESENT);
  assign bus.irq_id    = irq_id;
  assign bus.m_psel    = psel_q;
  assign bus.m_penable = penable_q;
  assign bus.m_pwrite  = pwrite_q;
  assign bus.m_pstrb   = pstrb_q;
  assign bus.m_pwdata  = pwdata_q;
endmodule

// File: tb/tb_gpio_ctrl_intr_dispatch.sv
// Bench for gpio_ctrl_intr_dispatch: an 8-bank and a 32-bank instance share stimulus; the idle one
// is kept quiet via its bank_en. Expected IDs come from a round-robin pick over the pending set.
module tb_gpio_ctrl_intr_dispatch;
  localparam int H8  = 4;
  localparam int H32 = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] status;
  logic [7:0]  en8;
  logic [31:0] en32;
  logic        claim, complete, pready;
  logic        sel32;
  logic        busy8, busy32;

  int n_tests = 0;
  int n_fail  = 0;
  int rr[2];

  always #5 clk = ~clk;

  gpio_ctrl_intr_dispatch_if #(.ID_W(3)) b8 ();
  gpio_ctrl_intr_dispatch_if #(.ID_W(5)) b32 ();

  assign b8.claim     = claim;
  assign b8.complete  = complete;
  assign b8.m_pready  = pready;
  assign b32.claim    = claim;
  assign b32.complete = complete;
  assign b32.m_pready = pready;

  gpio_ctrl_intr_dispatch #(.NUM_BANKS(8), .HOLDOFF_CYCLES(H8)) u8 (
    .clk(clk), .rst_n(rst_n), .intr_status(status[7:0]), .bank_en(en8),
    .busy(busy8), .bus(b8)
  );

  gpio_ctrl_intr_dispatch #(.NUM_BANKS(32), .HOLDOFF_CYCLES(H32)) u32 (
    .clk(clk), .rst_n(rst_n), .intr_status(status), .bank_en(en32),
    .busy(busy32), .bus(b32)
  );

  logic        o_irq, o_busy, o_psel, o_pen, o_pwrite;
  logic [4:0]  o_id;
  logic [3:0]  o_strb;
  logic [31:0] o_wdata;

  always_comb begin
    o_irq    = sel32 ? b32.irq       : b8.irq;
    o_id     = sel32 ? b32.irq_id    : {2'b00, b8.irq_id};
    o_busy   = sel32 ? busy32        : busy8;
    o_psel   = sel32 ? b32.m_psel    : b8.m_psel;
    o_pen    = sel32 ? b32.m_penable : b8.m_penable;
    o_pwrite = sel32 ? b32.m_pwrite  : b8.m_pwrite;
    o_strb   = sel32 ? b32.m_pstrb   : b8.m_pstrb;
    o_wdata  = sel32 ? b32.m_pwdata  : b8.m_pwdata;
  end

  function automatic int cur_n();
    return sel32 ? 32 : 8;
  endfunction

  function automatic int cur_hold();
    int h;
    h = sel32 ? H32 : H8;
    return (h == 0) ? 1 : h;
  endfunction

  function automatic logic [31:0] pend_now();
    return status & (sel32 ? en32 : {24'h0, en8});
  endfunction

  // Reference: scan upward from the round-robin pointer, wrapping at the bank count.
  function automatic int rr_pick(input logic [31:0] p, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (p[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_irq(input int budget);
    int t;
    t = 0;
    while (!o_irq && t < budget) begin
      tick();
      t++;
    end
    chk("irq_wait", {31'b0, o_irq}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_irq"},    {31'b0, o_irq},    32'd0);
    chk({tag, "_busy"},   {31'b0, o_busy},   32'd0);
    chk({tag, "_psel"},   {31'b0, o_psel},   32'd0);
    chk({tag, "_pen"},    {31'b0, o_pen},    32'd0);
    chk({tag, "_pwrite"}, {31'b0, o_pwrite}, 32'd0);
    chk({tag, "_pstrb"},  {28'b0, o_strb},   32'd0);
    chk({tag, "_pwdata"}, o_wdata,           32'd0);
    chk({tag, "_id"},     {27'b0, o_id},     32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    tick();
    rst_n = 1'b1;
    rr[0] = 0;
    rr[1] = 0;
  endtask

  // Service the presented interrupt end to end; entered with irq already high.
  task automatic serve(input int id, input int cdl, input int cmd, input int pdl, input bit clr);
    int h;
    chk("irq_id", {27'b0, o_id}, id);
    repeat (cdl) begin
      tick();
      chk("irq_hold", {31'b0, o_irq}, 32'd1);
    end
    claim = 1'b1;
    tick();
    claim = 1'b0;
    chk("claim_irq_lo", {31'b0, o_irq}, 32'd0);
    chk("active_busy", {31'b0, o_busy}, 32'd1);
    repeat (cmd) begin
      tick();
      chk("active_nopsel", {31'b0, o_psel}, 32'd0);
    end
    complete = 1'b1;
    tick();
    complete = 1'b0;
    chk("setup_psel", {31'b0, o_psel}, 32'd1);
    chk("setup_pen", {31'b0, o_pen}, 32'd0);
    chk("setup_pwrite", {31'b0, o_pwrite}, 32'd1);
    chk("pwdata", o_wdata, 32'd1 << id);
    chk("pstrb", {28'b0, o_strb}, 32'd1 << (id / 8));
    tick();
    chk("access_psel", {31'b0, o_psel}, 32'd1);
    chk("access_pen", {31'b0, o_pen}, 32'd1);
    repeat (pdl) begin
      tick();
      chk("wait_psel", {31'b0, o_psel}, 32'd1);
      chk("wait_pen", {31'b0, o_pen}, 32'd1);
      chk("wait_pwdata", o_wdata, 32'd1 << id);
    end
    pready = 1'b1;
    tick();
    pready = 1'b0;
    if (clr) status[id] = 1'b0;
    chk("post_psel", {31'b0, o_psel}, 32'd0);
    chk("holdoff_busy", {31'b0, o_busy}, 32'd1);
    rr[sel32 ? 1 : 0] = (id + 1) % cur_n();
    h = 1;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (!o_busy) break;
      h++;
    end
    chk("holdoff_len", h, cur_hold());
  endtask

  initial begin
    int e;
    status   = '0;
    en8      = 8'hFF;
    en32     = '0;
    claim    = 1'b0;
    complete = 1'b0;
    pready   = 1'b0;
    sel32    = 1'b0;
    #2;
    pulse_reset("rst0");

    // Single bank: latency, one write, holdoff.
    status = 32'h04;
    tick();
    chk("lat1_irq", {31'b0, o_irq}, 32'd0);
    tick();
    chk("lat2_irq", {31'b0, o_irq}, 32'd1);
    e = rr_pick(pend_now(), rr[0], 8);
    serve(e, 1, 1, 0, 1'b1);

    // Two banks held pending: round-robin alternates.
    pulse_reset("rst1");
    status = 32'h81;
    for (int i = 0; i < 4; i++) begin
      e = rr_pick(pend_now(), rr[0], 8);
      wait_irq(10);
      serve(e, 0, 0, 0, 1'b0);
    end
    status = '0;
    tick();

    // Withdrawal while presented, then claim racing withdrawal.
    status = 32'h08;
    wait_irq(10);
    chk("wd_id", {27'b0, o_id}, 32'd3);
    en8[3] = 1'b0;
    tick();
    chk("wd_irq", {31'b0, o_irq}, 32'd0);
    chk("wd_busy", {31'b0, o_busy}, 32'd0);
    chk("wd_psel", {31'b0, o_psel}, 32'd0);
    tick();
    chk("wd_idle", {31'b0, o_busy}, 32'd0);
    en8[3] = 1'b1;
    wait_irq(10);
    claim  = 1'b1;
    en8[3] = 1'b0;
    tick();
    claim = 1'b0;
    chk("race_irq", {31'b0, o_irq}, 32'd0);
    chk("race_busy", {31'b0, o_busy}, 32'd1);
    complete = 1'b1;
    tick();
    complete = 1'b0;
    chk("race_psel", {31'b0, o_psel}, 32'd1);
    chk("race_pwdata", o_wdata, 32'h8);
    tick();
    pready = 1'b1;
    tick();
    pready    = 1'b0;
    status[3] = 1'b0;
    rr[0]     = 4;
    en8       = 8'hFF;
    for (int t = 0; t < 20 && o_busy; t++) tick();
    chk("race_done", {31'b0, o_busy}, 32'd0);

    // Stray claim in IDLE, stray complete in PRESENT.
    claim = 1'b1;
    tick();
    claim = 1'b0;
    chk("idle_claim_busy", {31'b0, o_busy}, 32'd0);
    tick();
    chk("idle_claim_irq", {31'b0, o_irq}, 32'd0);
    status = 32'h40;
    e = rr_pick(pend_now(), rr[0], 8);
    wait_irq(10);
    complete = 1'b1;
    tick();
    complete = 1'b0;
    chk("pres_complete_irq", {31'b0, o_irq}, 32'd1);
    tick();
    chk("pres_complete_psel", {31'b0, o_psel}, 32'd0);
    serve(e, 0, 0, 1, 1'b1);

    // Reset during ACCESS abandons the transfer; pointer restarts at 0.
    status = 32'h22;
    wait_irq(10);
    claim = 1'b1;
    tick();
    claim    = 1'b0;
    complete = 1'b1;
    tick();
    complete = 1'b0;
    tick();
    chk("pre_rst_pen", {31'b0, o_pen}, 32'd1);
    pulse_reset("rst_access");
    for (int i = 0; i < 2; i++) begin
      e = rr_pick(pend_now(), rr[0], 8);
      wait_irq(10);
      serve(e, 0, 1, 0, 1'b1);
    end

    // 32-bank instance: high bank, upper strobe, slow pready, zero holdoff.
    sel32  = 1'b1;
    en8    = 8'h00;
    en32   = 32'hFFFF_FFFF;
    status = 32'h0800_0000;
    e = rr_pick(pend_now(), rr[1], 32);
    wait_irq(10);
    serve(e, 0, 1, 3, 1'b1);

    // Randomized dispatch on both instances.
    for (int d = 0; d < 2; d++) begin
      sel32  = (d == 1);
      status = '0;
      en8    = 8'h00;
      en32   = '0;
      tick();
      for (int i = 0; i < 15; i++) begin
        int b;
        if (d == 1) begin
          status = status | $urandom();
          en32   = $urandom();
        end else begin
          status = status | {24'h0, 8'($urandom())};
          en8    = 8'($urandom());
        end
        if (pend_now() == 0) begin
          b = $urandom_range(0, cur_n() - 1);
          status[b] = 1'b1;
          if (d == 1) en32[b] = 1'b1; else en8[b] = 1'b1;
        end
        e = rr_pick(pend_now(), rr[d], cur_n());
        wait_irq(10);
        serve(e, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end
      status = '0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
